// File: rtl/cpu_control_unit.sv
// Moore control FSM for the 8-bit CPU datapath: fetch, decode and execute sequencing
// including the one-cycle read latency of the synchronous ROM and data memory.
module cpu_control_unit #(
    parameter logic [2:0] ALU_ADD   = 3'b000,
    parameter logic [2:0] ALU_SUB   = 3'b001,
    parameter logic [2:0] ALU_AND   = 3'b010,
    parameter logic [2:0] ALU_OR    = 3'b011,
    parameter logic [2:0] ALU_INC   = 3'b100,
    parameter logic [2:0] ALU_DEC   = 3'b101,
    parameter logic [1:0] BUS1_PC   = 2'b00,
    parameter logic [1:0] BUS1_A    = 2'b01,
    parameter logic [1:0] BUS1_B    = 2'b10,
    parameter logic [1:0] BUS2_ALU  = 2'b00,
    parameter logic [1:0] BUS2_BUS1 = 2'b01,
    parameter logic [1:0] BUS2_MEM  = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic       CCR_Load,
    output logic [2:0] ALU_Sel,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write,
    output logic [4:0] fsm_state
);

    localparam logic [7:0] OP_LDA_IMM = 8'h10;
    localparam logic [7:0] OP_LDA_DIR = 8'h11;
    localparam logic [7:0] OP_LDB_IMM = 8'h12;
    localparam logic [7:0] OP_LDB_DIR = 8'h13;
    localparam logic [7:0] OP_STA_DIR = 8'h14;
    localparam logic [7:0] OP_STB_DIR = 8'h15;
    localparam logic [7:0] OP_ADD_AB  = 8'h20;
    localparam logic [7:0] OP_SUB_AB  = 8'h21;
    localparam logic [7:0] OP_AND_AB  = 8'h22;
    localparam logic [7:0] OP_OR_AB   = 8'h23;
    localparam logic [7:0] OP_INCA    = 8'h24;
    localparam logic [7:0] OP_INCB    = 8'h25;
    localparam logic [7:0] OP_DECA    = 8'h26;
    localparam logic [7:0] OP_DECB    = 8'h27;
    localparam logic [7:0] OP_BRA     = 8'h30;
    localparam logic [7:0] OP_BNU     = 8'h31;
    localparam logic [7:0] OP_BND     = 8'h32;
    localparam logic [7:0] OP_BZU     = 8'h33;
    localparam logic [7:0] OP_BZD     = 8'h34;
    localparam logic [7:0] OP_BVU     = 8'h35;
    localparam logic [7:0] OP_BVD     = 8'h36;
    localparam logic [7:0] OP_BCU     = 8'h37;
    localparam logic [7:0] OP_BCD     = 8'h38;

    localparam logic [4:0] S_F0     = 5'd0;
    localparam logic [4:0] S_F1     = 5'd1;
    localparam logic [4:0] S_F2     = 5'd2;
    localparam logic [4:0] S_D3     = 5'd3;
    localparam logic [4:0] S_OP0    = 5'd4;
    localparam logic [4:0] S_OP1    = 5'd5;
    localparam logic [4:0] S_OP1_BR = 5'd6;
    localparam logic [4:0] S_D0     = 5'd7;
    localparam logic [4:0] S_D1     = 5'd8;
    localparam logic [4:0] S_LDA    = 5'd9;
    localparam logic [4:0] S_LDB    = 5'd10;
    localparam logic [4:0] S_STA    = 5'd11;
    localparam logic [4:0] S_STB    = 5'd12;
    localparam logic [4:0] S_ADD    = 5'd13;
    localparam logic [4:0] S_SUB    = 5'd14;
    localparam logic [4:0] S_AND    = 5'd15;
    localparam logic [4:0] S_OR     = 5'd16;
    localparam logic [4:0] S_INCA   = 5'd17;
    localparam logic [4:0] S_INCB   = 5'd18;
    localparam logic [4:0] S_DECA   = 5'd19;
    localparam logic [4:0] S_DECB   = 5'd20;
    localparam logic [4:0] S_BR     = 5'd21;
    localparam logic [4:0] S_SKIP   = 5'd22;

    logic [4:0] state;
    logic [4:0] state_next;
    logic       is_branch;
    logic       branch_taken;
    logic       flag_n, flag_z, flag_v, flag_c;

    assign flag_n    = CCR_Result[3];
    assign flag_z    = CCR_Result[2];
    assign flag_v    = CCR_Result[1];
    assign flag_c    = CCR_Result[0];
    assign fsm_state = state;

    // Only consulted in D3; OP0 relies on the fact that only taken branches reach it.
    always_comb begin
        is_branch    = 1'b1;
        branch_taken = 1'b0;
        case (IR)
            OP_BRA:  branch_taken = 1'b1;
            OP_BNU:  branch_taken = flag_n;
            OP_BND:  branch_taken = ~flag_n;
            OP_BZU:  branch_taken = flag_z;
            OP_BZD:  branch_taken = ~flag_z;
            OP_BVU:  branch_taken = flag_v;
            OP_BVD:  branch_taken = ~flag_v;
            OP_BCU:  branch_taken = flag_c;
            OP_BCD:  branch_taken = ~flag_c;
            default: is_branch    = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_F0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_F0;
        case (state)
            S_F0: state_next = S_F1;
            S_F1: state_next = S_F2;
            S_F2: state_next = S_D3;
            S_D3: begin
                case (IR)
                    OP_LDA_IMM, OP_LDA_DIR, OP_LDB_IMM,
                    OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: state_next = S_OP0;
                    OP_ADD_AB: state_next = S_ADD;
                    OP_SUB_AB: state_next = S_SUB;
                    OP_AND_AB: state_next = S_AND;
                    OP_OR_AB:  state_next = S_OR;
                    OP_INCA:   state_next = S_INCA;
                    OP_INCB:   state_next = S_INCB;
                    OP_DECA:   state_next = S_DECA;
                    OP_DECB:   state_next = S_DECB;
                    default: begin
                        if (is_branch) begin
                            state_next = branch_taken ? S_OP0 : S_SKIP;
                        end else begin
                            state_next = S_F0;
                        end
                    end
                endcase
            end
            S_OP0:    state_next = is_branch ? S_OP1_BR : S_OP1;
            S_OP1: begin
                case (IR)
                    OP_LDA_IMM: state_next = S_LDA;
                    OP_LDB_IMM: state_next = S_LDB;
                    OP_LDA_DIR, OP_LDB_DIR,
                    OP_STA_DIR, OP_STB_DIR: state_next = S_D0;
                    default: state_next = S_F0;
                endcase
            end
            S_OP1_BR: state_next = S_BR;
            S_D0: begin
                case (IR)
                    OP_LDA_DIR, OP_LDB_DIR: state_next = S_D1;
                    OP_STA_DIR: state_next = S_STA;
                    OP_STB_DIR: state_next = S_STB;
                    default:    state_next = S_F0;
                endcase
            end
            S_D1: begin
                case (IR)
                    OP_LDA_DIR: state_next = S_LDA;
                    OP_LDB_DIR: state_next = S_LDB;
                    default:    state_next = S_F0;
                endcase
            end
            default: state_next = S_F0;
        endcase
    end

    // Moore outputs: every strobe and select is a function of state alone.
    always_comb begin
        IR_Load  = 1'b0;
        MAR_Load = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        A_Load   = 1'b0;
        B_Load   = 1'b0;
        CCR_Load = 1'b0;
        ALU_Sel  = ALU_ADD;
        Bus1_Sel = BUS1_PC;
        Bus2_Sel = BUS2_ALU;
        write    = 1'b0;
        case (state)
            S_F0, S_OP0: begin
                Bus1_Sel = BUS1_PC;
                Bus2_Sel = BUS2_BUS1;
                MAR_Load = 1'b1;
            end
            S_F1, S_OP1, S_SKIP: PC_Inc = 1'b1;
            S_F2: begin
                Bus2_Sel = BUS2_MEM;
                IR_Load  = 1'b1;
            end
            S_D0: begin
                Bus2_Sel = BUS2_MEM;
                MAR_Load = 1'b1;
            end
            S_LDA: begin
                Bus2_Sel = BUS2_MEM;
                A_Load   = 1'b1;
            end
            S_LDB: begin
                Bus2_Sel = BUS2_MEM;
                B_Load   = 1'b1;
            end
            S_STA: begin
                Bus1_Sel = BUS1_A;
                write    = 1'b1;
            end
            S_STB: begin
                Bus1_Sel = BUS1_B;
                write    = 1'b1;
            end
            S_ADD, S_SUB, S_AND, S_OR, S_INCA, S_DECA: begin
                Bus1_Sel = BUS1_A;
                Bus2_Sel = BUS2_ALU;
                A_Load   = 1'b1;
                CCR_Load = 1'b1;
            end
            S_INCB, S_DECB: begin
                Bus1_Sel = BUS1_B;
                Bus2_Sel = BUS2_ALU;
                B_Load   = 1'b1;
                CCR_Load = 1'b1;
            end
            S_BR: begin
                Bus2_Sel = BUS2_MEM;
                PC_Load  = 1'b1;
            end
            default: ;
        endcase
        case (state)
            S_SUB:          ALU_Sel = ALU_SUB;
            S_AND:          ALU_Sel = ALU_AND;
            S_OR:           ALU_Sel = ALU_OR;
            S_INCA, S_INCB: ALU_Sel = ALU_INC;
            S_DECA, S_DECB: ALU_Sel = ALU_DEC;
            default:        ALU_Sel = ALU_ADD;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: per-cycle output traces from an instruction-level model,
// a directed instruction table, reset corner cases and random instruction streams.
module tb_cpu_control_unit;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_INC   = 3'b100;
    localparam logic [2:0] ALU_DEC   = 3'b101;
    localparam logic [1:0] BUS1_PC   = 2'b00;
    localparam logic [1:0] BUS1_A    = 2'b01;
    localparam logic [1:0] BUS1_B    = 2'b10;
    localparam logic [1:0] BUS2_ALU  = 2'b00;
    localparam logic [1:0] BUS2_BUS1 = 2'b01;
    localparam logic [1:0] BUS2_MEM  = 2'b10;

    logic       clk;
    logic       reset;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load, write;
    logic [2:0] ALU_Sel;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic [4:0] fsm_state;

    logic [14:0] act;
    logic [14:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    cpu_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .IR         (IR),
        .CCR_Result (CCR_Result),
        .IR_Load    (IR_Load),
        .MAR_Load   (MAR_Load),
        .PC_Load    (PC_Load),
        .PC_Inc     (PC_Inc),
        .A_Load     (A_Load),
        .B_Load     (B_Load),
        .CCR_Load   (CCR_Load),
        .ALU_Sel    (ALU_Sel),
        .Bus1_Sel   (Bus1_Sel),
        .Bus2_Sel   (Bus2_Sel),
        .write      (write),
        .fsm_state  (fsm_state)
    );

    assign act = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load,
                  ALU_Sel, Bus1_Sel, Bus2_Sel, write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] wd(input logic irl, input logic marl, input logic pcl,
                                       input logic pci, input logic al, input logic bl,
                                       input logic ccrl, input logic [2:0] alu,
                                       input logic [1:0] b1, input logic [1:0] b2,
                                       input logic wr);
        return {irl, marl, pcl, pci, al, bl, ccrl, alu, b1, b2, wr};
    endfunction

    // Word shapes named after what the datapath is doing in that cycle.
    logic [14:0] w_addr, w_inc, w_fetch_ir, w_idle, w_indirect;
    initial begin
        w_addr     = wd(0, 1, 0, 0, 0, 0, 0, ALU_ADD, BUS1_PC, BUS2_BUS1, 0);
        w_inc      = wd(0, 0, 0, 1, 0, 0, 0, ALU_ADD, BUS1_PC, BUS2_ALU, 0);
        w_fetch_ir = wd(1, 0, 0, 0, 0, 0, 0, ALU_ADD, BUS1_PC, BUS2_MEM, 0);
        w_idle     = wd(0, 0, 0, 0, 0, 0, 0, ALU_ADD, BUS1_PC, BUS2_ALU, 0);
        w_indirect = wd(0, 1, 0, 0, 0, 0, 0, ALU_ADD, BUS1_PC, BUS2_MEM, 0);
    end

    // Instruction-level reference: appends the full cycle trace of one instruction.
    task automatic model_instr(input logic [7:0] op, input logic [3:0] ccr);
        logic taken;
        logic is_br;
        exp_q.push_back(w_addr);
        exp_q.push_back(w_inc);
        exp_q.push_back(w_fetch_ir);
        exp_q.push_back(w_idle);
        is_br = 1'b1;
        taken = 1'b0;
        case (op)
            8'h30: taken = 1'b1;
            8'h31: taken = ccr[3];
            8'h32: taken = !ccr[3];
            8'h33: taken = ccr[2];
            8'h34: taken = !ccr[2];
            8'h35: taken = ccr[1];
            8'h36: taken = !ccr[1];
            8'h37: taken = ccr[0];
            8'h38: taken = !ccr[0];
            default: is_br = 1'b0;
        endcase
        if (op == 8'h10 || op == 8'h12) begin
            exp_q.push_back(w_addr);
            exp_q.push_back(w_inc);
            exp_q.push_back(wd(0, 0, 0, 0, op == 8'h10, op == 8'h12, 0, ALU_ADD, BUS1_PC, BUS2_MEM, 0));
        end else if (op == 8'h11 || op == 8'h13) begin
            exp_q.push_back(w_addr);
            exp_q.push_back(w_inc);
            exp_q.push_back(w_indirect);
            exp_q.push_back(w_idle);
            exp_q.push_back(wd(0, 0, 0, 0, op == 8'h11, op == 8'h13, 0, ALU_ADD, BUS1_PC, BUS2_MEM, 0));
        end else if (op == 8'h14 || op == 8'h15) begin
            exp_q.push_back(w_addr);
            exp_q.push_back(w_inc);
            exp_q.push_back(w_indirect);
            exp_q.push_back(wd(0, 0, 0, 0, 0, 0, 0, ALU_ADD, (op == 8'h14) ? BUS1_A : BUS1_B, BUS2_ALU, 1));
        end else if (op >= 8'h20 && op <= 8'h27) begin
            logic [2:0] alu_ops[8];
            logic       to_b;
            alu_ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_INC, ALU_INC, ALU_DEC, ALU_DEC};
            to_b = (op == 8'h25 || op == 8'h27);
            exp_q.push_back(wd(0, 0, 0, 0, !to_b, to_b, 1, alu_ops[op - 8'h20],
                               to_b ? BUS1_B : BUS1_A, BUS2_ALU, 0));
        end else if (is_br && taken) begin
            exp_q.push_back(w_addr);
            exp_q.push_back(w_idle);
            exp_q.push_back(wd(0, 0, 1, 0, 0, 0, 0, ALU_ADD, BUS1_PC, BUS2_MEM, 0));
        end else if (is_br) begin
            exp_q.push_back(w_inc);
        end
    endtask

    task automatic check_word(input string name, input logic [14:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_cycle(input logic [7:0] op, input int c);
        n_checks++;
        if (($countones({A_Load, B_Load, PC_Load, IR_Load}) > 1) || (PC_Inc && PC_Load)) begin
            n_fail++;
            $display("FAIL strobe_exclusive: op %h cycle %0d got %h", op, c, act);
        end
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL trace_underflow: op %h cycle %0d got %h expected none", op, c, act);
        end else begin
            check_word($sformatf("trace op %h cycle %0d", op, c), exp_q.pop_front());
        end
    endtask

    // Called #1 after a rising edge with the DUT in F0; returns the same way at the next F0.
    // cycles=0 runs the model's own length; ccr_late replaces the flags once D3 has passed.
    task automatic run_instr(input logic [7:0] op, input logic [3:0] ccr, input logic [3:0] ccr_late,
                             input int cycles, output int n_inc, output int n_wr);
        int len;
        IR         = op;
        CCR_Result = ccr;
        exp_q.delete();
        model_instr(op, ccr);
        len   = (cycles == 0) ? exp_q.size() : cycles;
        n_inc = 0;
        n_wr  = 0;
        for (int c = 1; c <= len; c++) begin
            if (c == 5) CCR_Result = ccr_late;
            @(negedge clk);
            check_cycle(op, c);
            n_inc += int'(PC_Inc);
            n_wr  += int'(write);
            @(posedge clk);
            #1;
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_word("reset_async_f0", w_addr);
        @(posedge clk);
        #1;
        check_word("reset_hold_f0", w_addr);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [7:0] op;
        logic [3:0] ccr;
        logic [3:0] ccr_late;
        int         cycles;
        int         incs;
        int         writes;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] valid_ops[29];

    initial begin
        int n_inc, n_wr;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        IR         = 8'h00;
        CCR_Result = 4'h0;
        valid_ops  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                       8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27,
                       8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                       8'h10, 8'h14, 8'h20, 8'h33, 8'h11, 8'h27};

        vecs.push_back(vec_t'{8'h10, 4'h0, 4'h0, 7, 2, 0});
        vecs.push_back(vec_t'{8'h14, 4'h0, 4'h0, 8, 2, 1});
        vecs.push_back(vec_t'{8'h20, 4'h0, 4'h0, 5, 1, 0});
        vecs.push_back(vec_t'{8'h27, 4'h0, 4'h0, 5, 1, 0});
        vecs.push_back(vec_t'{8'h33, 4'h4, 4'h0, 7, 1, 0});
        vecs.push_back(vec_t'{8'h33, 4'h0, 4'h4, 5, 2, 0});
        vecs.push_back(vec_t'{8'hFF, 4'h0, 4'h0, 4, 1, 0});
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(vec_t'{8'h10, 4'h0, 4'h0, 7, 2, 0});
            vecs.push_back(vec_t'{8'h14, 4'h0, 4'h0, 8, 2, 1});
            vecs.push_back(vec_t'{8'h30, 4'h0, 4'h0, 7, 1, 0});
        end
        vecs.push_back(vec_t'{8'h11, 4'h0, 4'h0, 9, 2, 0});
        vecs.push_back(vec_t'{8'h12, 4'hF, 4'h0, 7, 2, 0});
        vecs.push_back(vec_t'{8'h13, 4'h0, 4'hF, 9, 2, 0});
        vecs.push_back(vec_t'{8'h15, 4'h0, 4'h0, 8, 2, 1});
        vecs.push_back(vec_t'{8'h21, 4'h0, 4'h0, 5, 1, 0});
        vecs.push_back(vec_t'{8'h22, 4'h0, 4'h0, 5, 1, 0});
        vecs.push_back(vec_t'{8'h23, 4'h0, 4'h0, 5, 1, 0});
        vecs.push_back(vec_t'{8'h24, 4'h0, 4'h0, 5, 1, 0});
        vecs.push_back(vec_t'{8'h25, 4'h0, 4'h0, 5, 1, 0});
        vecs.push_back(vec_t'{8'h26, 4'h0, 4'h0, 5, 1, 0});
        vecs.push_back(vec_t'{8'h31, 4'h8, 4'h0, 7, 1, 0});
        vecs.push_back(vec_t'{8'h32, 4'h8, 4'h0, 5, 2, 0});
        vecs.push_back(vec_t'{8'h34, 4'h0, 4'hF, 7, 1, 0});
        vecs.push_back(vec_t'{8'h35, 4'h2, 4'h0, 7, 1, 0});
        vecs.push_back(vec_t'{8'h36, 4'h2, 4'h0, 5, 2, 0});
        vecs.push_back(vec_t'{8'h37, 4'h1, 4'h0, 7, 1, 0});
        vecs.push_back(vec_t'{8'h38, 4'h1, 4'h0, 5, 2, 0});

        #3;
        check_word("reset_initial_f0", w_addr);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].ccr, vecs[i].ccr_late, vecs[i].cycles, n_inc, n_wr);
            n_checks++;
            if (n_inc != vecs[i].incs) begin
                n_fail++;
                $display("FAIL pc_inc_count op %h: got %0d expected %0d", vecs[i].op, n_inc, vecs[i].incs);
            end
            n_checks++;
            if (n_wr != vecs[i].writes) begin
                n_fail++;
                $display("FAIL write_count op %h: got %0d expected %0d", vecs[i].op, n_wr, vecs[i].writes);
            end
        end

        // Abort a store in its D0 cycle, then release and watch fetch restart.
        run_instr(8'h14, 4'h0, 4'h0, 6, n_inc, n_wr);
        @(negedge clk);
        check_word("store_d0_before_reset", w_indirect);
        #2;
        do_reset();
        @(negedge clk);
        check_word("after_release_f0", w_addr);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_word("after_release_f1", w_inc);
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 150; i++) begin
            logic [7:0] op;
            if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(0, 255));
            else op = valid_ops[$urandom_range(0, 28)];
            run_instr(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, n_inc, n_wr);
        end

        @(negedge clk);
        check_word("final_f0", w_addr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Moore-style finite state machine that sequences the 8-bit CPU datapath: program counter (PC), memory address register (MAR), instruction register (IR), registers A/B, ALU, condition-code register (CCR) and the two internal buses. It runs the fetch / decode / execute cycle for the full instruction set, accounting for the one-cycle read latency of the synchronous program ROM and data memory. It sits beside the datapath inside the CPU. Its only inputs are the IR contents and the CCR flags.

## Interface
Parameters:
- ALU_ADD 3'b000, ALU_SUB 3'b001, ALU_AND 3'b010, ALU_OR 3'b011, ALU_INC 3'b100, ALU_DEC 3'b101: ALU_Sel encodings.
- BUS1_PC 2'b00, BUS1_A 2'b01, BUS1_B 2'b10: Bus1 source select.
- BUS2_ALU 2'b00, BUS2_BUS1 2'b01, BUS2_MEM 2'b10: Bus2 source select.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- IR  in  8  current instruction register contents (opcode).
- CCR_Result  in  4  flags {N,Z,V,C}, sampled in DECODE.
- IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  out  1 each  datapath register strobes.
- ALU_Sel  out  3  ALU operation.
- Bus1_Sel  out  2  Bus1 source select.
- Bus2_Sel  out  2  Bus2 source select.
- write  out  1  data-memory write enable.

## Operation
- Opcodes:
  - Loads/stores: LDA_IMM 10, LDA_DIR 11, LDB_IMM 12, LDB_DIR 13, STA_DIR 14, STB_DIR 15.
  - ALU: ADD_AB 20, SUB_AB 21, AND_AB 22, OR_AB 23, INCA 24, INCB 25, DECA 26, DECB 27.
  - Branches: BRA 30, BNU 31 (N=1), BND 32 (N=0), BZU 33 (Z=1), BZD 34 (Z=0), BVU 35, BVD 36, BCU 37, BCD 38.
- Outputs are decoded from the state register only (Moore). Any output not listed for a state is 0, including selects (Bus1 = PC, Bus2 = ALU).
- Fetch sequence:
  - F0: Bus1=PC, Bus2=BUS1, MAR_Load.
  - F1: PC_Inc (ROM read in flight).
  - F2: Bus2=MEM, IR_Load.
  - D3: no strobes; next state is selected from IR and CCR_Result.
- Operand fetch (OP), common to immediate, direct and taken branches:
  - OP0: Bus1=PC, Bus2=BUS1, MAR_Load.
  - OP1: PC_Inc. Taken branches do not assert PC_Inc here.
- Immediate loads: OP0, OP1, then X: Bus2=MEM, A_Load (B_Load for LDB).
- Direct loads: OP0, OP1, then D0: Bus2=MEM, MAR_Load; then D1: wait; then X: Bus2=MEM, A_Load or B_Load.
- Stores: OP0, OP1, D0, then X: Bus1=A (or B), write.
- ALU operations, one execute state:
  - ALU_Sel per opcode, Bus2=ALU, CCR_Load.
  - Destination A (Bus1=A, A_Load) for ADD/SUB/AND/OR/INCA/DECA.
  - Destination B (Bus1=B, B_Load) for INCB/DECB.
- Taken branch: OP0, OP1 (no increment), then X: Bus2=MEM, PC_Load.
- Untaken conditional branch: one state asserting PC_Inc to skip the operand.
- Every execute path returns to F0.
- An undefined opcode is a NOP: D3 goes directly to F0.

## Timing
- Reset (reset=0): state forced to F0 immediately, asynchronously. Outputs read F0 values: MAR_Load=1, Bus2_Sel=BUS2_BUS1, all others 0.
- Deasserting reset: the first rising edge leaves F0.
- Cycles per instruction, counted from F0 to the next F0:
  - ALU op: 5.
  - Untaken branch: 5.
  - Immediate load: 7.
  - Taken branch: 7.
  - Store: 8.
  - Direct load: 9.
- Flags are sampled only in D3. CCR_Load in the same instruction does not affect that instruction's branch decision.
- Reset asserted mid-instruction aborts it. No write or load strobe is issued after the reset edge.
- At most one of A_Load, B_Load, PC_Load, IR_Load is asserted in any cycle. PC_Inc and PC_Load are never asserted together.

## Test plan
- **Reset:** assert reset=0 mid-execute.
  - Outputs show F0 values immediately: MAR_Load=1, write=0.
  - Release reset: F1 follows with PC_Inc=1.
- **Immediate load:** run LDA_IMM AA.
  - Exactly 7 cycles.
  - A_Load and Bus2_Sel=10 in cycle 7 only.
  - PC_Inc pulses twice.
- **Store:** run STA_DIR E0.
  - write=1 with Bus1_Sel=01 in cycle 8 only.
  - MAR_Load asserted in cycles 1, 5 and 7.
- **ALU ops:** run ADD_AB, then DECB.
  - ADD_AB: 5 cycles; ALU_Sel=000, A_Load, CCR_Load in cycle 5.
  - DECB: ALU_Sel=101, Bus1_Sel=10, B_Load.
- **Conditional branches:** BZU with CCR_Result=4'b0100, then 4'b0000.
  - Z=1 (taken): 7 cycles, PC_Load in the last cycle.
  - Z=0 (untaken): 5 cycles, PC_Inc in the last cycle, no PC_Load.
- **Undefined opcode and loop:** run opcode FF, then the loop LDA_IMM AA / STA_DIR E0 / BRA 00.
  - Opcode FF: returns to F0 after 4 cycles with no load or write strobes.
  - Loop: repeats every 22 cycles.
